// File: rtl/booth_mul_4bit.sv
// booth_mul_4bit
//   Sequential signed radix-2 Booth multiplier. One add/subtract/shift
//   iteration per clock, WIDTH iterations per product.
//
//   Ports
//     clk          in   system clock, rising edge
//     rst          in   asynchronous active-high reset
//     start        in   request pulse, only sampled while idle
//     multiplicand in   [WIDTH-1:0]   signed operand M
//     multiplier   in   [WIDTH-1:0]   signed operand Q
//     busy         out  high while iterating
//     done         out  one-cycle pulse, product valid from this cycle on
//     product      out  [2*WIDTH-1:0] signed M*Q, held until next result
//     addsub_count out  [$clog2(WIDTH+1)-1:0] number of add/sub iterations
//                       (present only when BOOTH_STATS_EN is defined)
//
//   Optional build macro: BOOTH_STATS_EN
module booth_mul_4bit #(
    parameter int WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [WIDTH-1:0]              multiplicand,
    input  logic [WIDTH-1:0]              multiplier,
    output logic                          busy,
    output logic                          done,
    output logic [2*WIDTH-1:0]            product
`ifdef BOOTH_STATS_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0]    addsub_count
`endif
);

    localparam int CW = $clog2(WIDTH+1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nx;

    logic [WIDTH:0]   a, mx, sum, a_sh;
    logic [WIDTH-1:0] q, q_sh;
    logic             q_1;
    logic [CW-1:0]    cnt;
    logic             last;

    assign last = (cnt == CW'(WIDTH-1));

    // Booth step: add/sub on the WIDTH+1 bit accumulator, then arithmetic
    // shift of {A,Q,q_1}. The extra accumulator bit keeps -2^(WIDTH-1)
    // operands exact (e.g. -8*-8).
    always_comb begin
        sum = a;
        case ({q[0], q_1})
            2'b01:   sum = a + mx;
            2'b10:   sum = a + ~mx + (WIDTH+1)'(1);
            default: sum = a;
        endcase
        a_sh = {sum[WIDTH], sum[WIDTH:1]};
        q_sh = {sum[0], q[WIDTH-1:1]};
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CALC;
            CALC:    if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // outputs decoded from state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            CALC:    busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Datapath. The product register is written on the edge that enters
    // DONE, so its new value appears exactly in the done cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a       <= '0;
            mx      <= '0;
            q       <= '0;
            q_1     <= 1'b0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a   <= '0;
                    mx  <= {multiplicand[WIDTH-1], multiplicand};
                    q   <= multiplier;
                    q_1 <= 1'b0;
                    cnt <= '0;
                end
                CALC: begin
                    a   <= a_sh;
                    q   <= q_sh;
                    q_1 <= q[0];
                    cnt <= cnt + CW'(1);
                    if (last) product <= {a_sh[WIDTH-1:0], q_sh};
                end
                default: ;
            endcase
        end
    end

`ifdef BOOTH_STATS_EN
    logic [CW-1:0] ops;
    logic          addop;

    // 01 and 10 are exactly the patterns where the two bits differ
    assign addop = q[0] ^ q_1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ops          <= '0;
            addsub_count <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    ops          <= '0;
                    addsub_count <= '0;
                end
                CALC: begin
                    ops <= ops + CW'(addop);
                    if (last) addsub_count <= ops + CW'(addop);
                end
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_booth_mul_4bit.sv
module tb_booth_mul_4bit;

    logic       clk, rst, start;
    logic [3:0] multiplicand, multiplier;
    logic       busy, done;
    logic [7:0] product;
`ifdef BOOTH_STATS_EN
    logic [2:0] addsub_count;
`endif

    int npass = 0;
    int nchk  = 0;
    logic [7:0] last_prod;

    booth_mul_4bit #(.WIDTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
`ifdef BOOTH_STATS_EN
        ,
        .addsub_count (addsub_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            npass++;
    endtask

    // One multiply from idle. Operands are scrambled right after acceptance;
    // with reissue set, a second start pulse is given mid-flight.
    task automatic do_mul(input logic [3:0] m, input logic [3:0] q,
                          input logic [7:0] exp, input int exp_ops, input bit reissue);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        multiplicand = ~m;
        multiplier   = ~q;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("busy", {31'b0, busy}, 32'd1);
            chk("done_early", {31'b0, done}, 32'd0);
            chk("prod_hold", {24'b0, product}, {24'b0, last_prod});
            if (reissue && i == 1) begin
                start = 1'b1; multiplicand = 4'd1; multiplier = 4'd1;
            end
            if (reissue && i == 2) start = 1'b0;
        end
        @(negedge clk);
        chk("done", {31'b0, done}, 32'd1);
        chk("busy_done", {31'b0, busy}, 32'd0);
        chk("product", {24'b0, product}, {24'b0, exp});
`ifdef BOOTH_STATS_EN
        chk("addsub_count", {29'b0, addsub_count}, exp_ops);
`else
        if (exp_ops < 0) $display("bad ops arg");
`endif
        @(negedge clk);
        chk("done_pulse", {31'b0, done}, 32'd0);
        chk("busy_idle", {31'b0, busy}, 32'd0);
        chk("prod_after", {24'b0, product}, {24'b0, exp});
        last_prod = exp;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
        last_prod = 8'h00;
        #12;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_product", {24'b0, product}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_mul(4'd3,  4'd4,  8'd12,  2, 0);   // 3*4
        do_mul(4'h9,  4'h9,  8'd49,  3, 0);   // -7*-7
        do_mul(4'h8,  4'h8,  8'd64,  1, 0);   // -8*-8
        do_mul(4'd7,  4'h8,  8'hC8,  1, 0);   // 7*-8 = -56
        do_mul(4'd0,  4'hB,  8'h00,  3, 0);   // 0*-5
        do_mul(4'h8,  4'd7,  8'hC8,  2, 0);   // -8*7 = -56
        do_mul(4'd3,  4'hE,  8'hFA,  1, 1);   // 3*-2 = -6, mid-flight start ignored
        repeat (3) @(negedge clk);
        chk("ignored_start", {31'b0, done | busy}, 32'd0);
        chk("prod_held", {24'b0, product}, 32'h000000FA);

        // abort mid-multiply with an asynchronous reset
        begin
            bit seen = 0;
            multiplicand = 4'd5; multiplier = 4'd3; start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            @(posedge clk); @(posedge clk);
            #3 rst = 1'b1;
            #1;
            chk("arst_busy", {31'b0, busy}, 32'd0);
            chk("arst_done", {31'b0, done}, 32'd0);
            chk("arst_product", {24'b0, product}, 32'd0);
            @(negedge clk); rst = 1'b0;
            for (int i = 0; i < 7; i++) begin
                @(negedge clk);
                if (done || busy) seen = 1;
            end
            chk("no_done_after_rst", {31'b0, seen}, 32'd0);
            last_prod = 8'h00;
        end
        do_mul(4'd5, 4'd3, 8'd15, 2, 0);

        // back-to-back sweep with start held high: new operands are applied in
        // the done cycle and must be accepted WIDTH+2 cycles apart
        start = 1'b1;
        for (int k = 0; k < 256; k++) begin
            int mi, qi, p, n;
            logic [7:0] e;
            mi = (k / 16) - 8;
            qi = (k % 16) - 8;
            p  = mi * qi;
            e  = p[7:0];
            multiplicand = mi[3:0];
            multiplier   = qi[3:0];
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!done && n < 20);
            chk("sweep_product", {24'b0, product}, {24'b0, e});
            if (k > 0) chk("sweep_interval", n, 32'd6);
        end
        start = 1'b0;
        repeat (8) @(negedge clk);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/booth_mul_4bit.md
Name: booth_mul_4bit

Overview:
Sequential signed radix-2 Booth multiplier that sits downstream of the 4-bit signed adder/subtractor stage. It reuses the same add/subtract-by-two's-complement datapath once per iteration to form a full-width signed product. The upstream controller presents operands with a start pulse; the block returns the product with a one-cycle done pulse.

Parameters:
WIDTH, 4, operand width in bits (signed two's complement); product is 2*WIDTH bits.

Ports:
clk  input  1  single system clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  request pulse; sampled only in IDLE.
multiplicand  input  WIDTH  signed operand M.
multiplier  input  WIDTH  signed operand Q.
busy  output  1  high from the cycle after start is accepted until done is asserted.
done  output  1  one-cycle pulse; product valid from this cycle onward.
product  output  2*WIDTH  signed M*Q; held until the next accepted start.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, busy=0, done=0, product=0, all internal registers cleared. Any in-flight multiply is aborted, and no done is produced for it.
- Internal registers:
  - A: WIDTH+1 bits, signed accumulator; the extra bit absorbs -2^(WIDTH-1) corner cases.
  - Mx: WIDTH+1 bits, sign-extended multiplicand.
  - Q: WIDTH bits.
  - q_1: 1 bit.
  - cnt: counts WIDTH iterations.
- States: IDLE, CALC, DONE.
- IDLE:
  - If start=1 at a clock edge: A=0, Mx=sext(multiplicand), Q=multiplier, q_1=0, cnt=0, then go to CALC.
  - Otherwise remain in IDLE. busy=0.
- CALC, one iteration per cycle, based on {Q[0],q_1}:
  - 01: A+=Mx.
  - 10: A-=Mx, computed as A + ~Mx + 1.
  - 00 or 11: no operation.
  - In the same cycle, arithmetic-shift {A,Q,q_1} right by 1, replicating A's MSB.
  - cnt increments each iteration; after iteration WIDTH-1, go to DONE. busy=1.
- DONE:
  - product = low 2*WIDTH bits of {A,Q}; done=1 for exactly this cycle; busy=0.
  - Next state is IDLE unconditionally.
- Latency: start accepted at edge T; busy=1 for cycles T+1..T+WIDTH; done=1 and product valid at T+WIDTH+1. Minimum start-to-start interval is WIDTH+2 cycles.
- start while busy or in DONE is ignored; it is not queued.
- Operands are captured at acceptance, so later changes on the inputs have no effect on the result.
- Arithmetic: full signed result with no overflow possible. Range -(2^(WIDTH-1))*(2^(WIDTH-1)-1) .. 2^(2*WIDTH-2) fits in 2*WIDTH signed bits; -8*-8=64 is correct.
- product keeps its last value through IDLE and CALC and changes only in DONE or on reset.

Optional Feature:
Macro BOOTH_STATS_EN.
- Defined:
  - Adds output addsub_count, width $clog2(WIDTH+1), equal to the number of CALC iterations that performed an add or subtract (pattern 01 or 10).
  - Cleared on accepted start, updated with product in DONE, reset to 0.
- Undefined: the port and its logic are absent; the port list is exactly as above.

Test Plan:
1. Reset, then start with M=3, Q=4 -> busy for 4 cycles, done pulse at T+5, product=8'sd12 (addsub_count=2).
2. M=-7, Q=-7 -> product=8'sd49 (addsub_count=3); M=-8, Q=-8 -> product=8'sd64 (addsub_count=1).
3. M=7, Q=-8 -> product=-56 (8'hC8); M=-8, Q=7 -> product=-56; M=0, Q=-5 -> product=0.
4. Start at T, re-pulse start at T+2 with M=1, Q=1 -> ignored; single done at T+5 with the original product; product unchanged until the next accepted start.
5. Start M=5, Q=3, assert rst at T+2 asynchronously mid-clock -> busy, done and product go to 0 immediately; no done follows. After release, start M=5, Q=3 -> product=15.
6. Back-to-back starts issued each cycle done is seen -> accepted every WIDTH+2 cycles; exhaustive sweep of all 256 operand pairs matches the signed reference product.
